// File: rtl/ext_cpu_obi_arbiter.sv
// Round-robin merge of NMASTERS OBI core ports onto one bus port, with an in-order
// ID FIFO that steers each rvalid back to the master that issued the request.
package ext_cpu_obi_arbiter_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module ext_cpu_obi_arbiter
  import ext_cpu_obi_arbiter_pkg::*;
#(
  parameter int NMASTERS        = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  obi_req_t  [NMASTERS-1:0]           master_req_i,
  output obi_resp_t [NMASTERS-1:0]           master_resp_o,
  output obi_req_t                           slave_req_o,
  input  obi_resp_t                          slave_resp_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                               spurious_rvalid_o
);
  localparam int IW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [IW-1:0] ptr_q, ptr_d, lock_idx_q, lock_idx_d, sel, cand, head;
  logic          lock_q, lock_d, sel_vld, full, empty, hs, pop;
  logic [IW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [IW-1:0] fifo_d [MAX_OUTSTANDING];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          spur_q, spur_d;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (int'(p) == MAX_OUTSTANDING - 1) ? '0 : p + PW'(1);
  endfunction

  // A locked master keeps the bus until its handshake; otherwise the lowest
  // offset from ptr wins, so scan from the far end and let nearer hits overwrite.
  always_comb begin
    sel     = lock_q ? lock_idx_q : ptr_q;
    sel_vld = 1'b0;
    cand    = '0;
    if (lock_q) begin
      sel_vld = master_req_i[lock_idx_q].req;
    end else begin
      for (int k = NMASTERS - 1; k >= 0; k--) begin
        cand = IW'((int'(ptr_q) + k) % NMASTERS);
        if (master_req_i[cand].req) begin
          sel     = cand;
          sel_vld = 1'b1;
        end
      end
    end
  end

  assign full  = (cnt_q == CW'(MAX_OUTSTANDING));
  assign empty = (cnt_q == '0);
  assign head  = fifo_q[rd_q];

  always_comb begin
    slave_req_o     = master_req_i[sel];
    slave_req_o.req = sel_vld & ~full;
  end

  assign hs  = slave_req_o.req & slave_resp_i.gnt;
  assign pop = slave_resp_i.rvalid & ~empty;

  for (genvar i = 0; i < NMASTERS; i++) begin : g_resp
    logic hit;
    assign hit = pop && (head == IW'(i));
    assign master_resp_o[i] = '{gnt:    hs && (sel == IW'(i)),
                                rvalid: hit,
                                rdata:  hit ? slave_resp_i.rdata : 32'h0};
  end

  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    fifo_d     = fifo_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    spur_d     = spur_q | (slave_resp_i.rvalid & empty);
    if (hs) begin
      lock_d       = 1'b0;
      ptr_d        = (int'(sel) == NMASTERS - 1) ? '0 : sel + IW'(1);
      fifo_d[wr_q] = sel;
      wr_d         = nxt(wr_q);
    end else if (slave_req_o.req) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end
    if (pop) rd_d = nxt(rd_q);
    cnt_d = cnt_q + CW'(hs) - CW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      spur_q     <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      fifo_q     <= fifo_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      spur_q     <= spur_d;
    end
  end

  assign outstanding_o     = cnt_q;
  assign spurious_rvalid_o = spur_q;
endmodule

// File: doc/ext_cpu_obi_arbiter.md
EXT_CPU_OBI_ARBITER -- requirements
Module: ext_cpu_obi_arbiter

Interface
REQ-001 SHALL have parameter NMASTERS, default 2, number of OBI masters (core ports) merged.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, depth of the response-routing ID FIFO (power of 2, >=1).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-006 SHALL have port master_req_i  input  obi_req_t[NMASTERS]  per-core OBI requests (req, we, be, addr, wdata).
REQ-007 SHALL have port master_resp_o  output  obi_resp_t[NMASTERS]  per-core OBI responses (gnt, rvalid, rdata).
REQ-008 SHALL have port slave_req_o  output  obi_req_t  merged request to the bus.
REQ-009 SHALL have port slave_resp_i  input  obi_resp_t  bus response.
REQ-010 SHALL have port outstanding_o  output  $clog2(MAX_OUTSTANDING+1)  granted-but-unanswered transaction count.
REQ-011 SHALL have port spurious_rvalid_o  output  1  sticky flag, rvalid received with no outstanding transaction.

Function
REQ-012 SHALL select one requesting master per cycle by round-robin, searching upward from priority pointer ptr and wrapping from NMASTERS-1 to 0.
REQ-013 SHALL drive slave_req_o from the selected master combinationally; slave_req_o.req = selected req AND NOT fifo_full.
REQ-014 SHALL drive master_resp_o[i].gnt = slave_resp_i.gnt only for the selected master i while slave_req_o.req is high; all other gnt 0.
REQ-015 SHALL count a handshake when slave_req_o.req and slave_resp_i.gnt are both high; then push selected index into the ID FIFO and set ptr = (index+1) mod NMASTERS on the next edge.
REQ-016 SHALL lock the selection when slave_req_o.req is high without gnt; lock holds the same master (no re-arbitration) until that handshake, per OBI req-stability rule.
REQ-017 SHALL clear the lock on the handshake cycle; next cycle arbitrates afresh.
REQ-018 SHALL, when the FIFO holds MAX_OUTSTANDING entries, hold slave_req_o.req low and all gnt low; no push while full, even if a pop occurs the same cycle.
REQ-019 SHALL, on slave_resp_i.rvalid with FIFO non-empty, route rvalid and rdata to master FIFO-head in the same cycle (zero added latency) and pop the head.
REQ-020 SHALL drive rvalid 0 and rdata 0 to all non-head masters.
REQ-021 SHALL support push and pop in the same cycle when not full; occupancy unchanged.
REQ-022 SHALL, on rvalid with FIFO empty, forward to no master, leave FIFO unchanged, set spurious_rvalid_o (cleared only by reset).
REQ-023 SHALL keep outstanding_o equal to FIFO occupancy, updated registered.
REQ-024 SHALL keep response order in-order (OBI ordering); no reordering.

Reset
REQ-025 SHALL, while rst_i high at an edge: ptr=0, lock clear, FIFO empty, outstanding_o=0, spurious_rvalid_o=0.
REQ-026 SHALL, on reset mid-transaction, discard all outstanding IDs; a later rvalid for them raises spurious_rvalid_o.
REQ-027 SHALL output slave_req_o.req=0 and all master gnt/rvalid=0 in the cycle after reset when no master requests.

Verification
REQ-028 SHALL verify: both masters req continuously, gnt always 1 -> grants alternate M0,M1,M0,M1 starting with M0 after reset.
REQ-029 SHALL verify: M0 req addr 0x20010000, gnt low 3 cycles while M1 requests -> slave addr stays 0x20010000, M1 gnt 0 until M0 handshake.
REQ-030 SHALL verify: M0 then M1 granted, rvalid rdata 0xAAAA0000 then 0xBBBB1111 -> M0 receives 0xAAAA0000, M1 receives 0xBBBB1111, outstanding_o 2->1->0.
REQ-031 SHALL verify: MAX_OUTSTANDING=2, two grants, no rvalid -> third request sees slave req 0, gnt 0; after one rvalid, req reasserts next cycle.
REQ-032 SHALL verify: rvalid with outstanding_o=0 -> no master rvalid, spurious_rvalid_o=1 and stays 1 until rst_i.
REQ-033 SHALL verify: rst_i asserted with outstanding_o=1 -> outstanding_o=0 next cycle, ptr=0, subsequent rvalid sets spurious flag.
